// File: rtl/lru_miss_ctrl_pkg.sv
// Shared definitions for the 2-way cache miss controller.
// Includes the state encoding, line geometry and the way-selection rule.
package lru_miss_ctrl_pkg;

    localparam int WORDS   = 4;
    localparam int MEM_LAT = 2;
    localparam int OFF_W   = $clog2(WORDS);

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RD,
        FILL,
        DONE
    } state_t;

    // Hits win, then an empty way, then the LRU victim; a double hit falls to way 0.
    function automatic logic pick_way(input logic hit0, input logic hit1,
                                      input logic valid0, input logic valid1,
                                      input logic lru_bit);
        logic way;
        if (hit0)         way = 1'b0;
        else if (hit1)    way = 1'b1;
        else if (!valid0) way = 1'b0;
        else if (!valid1) way = 1'b1;
        else              way = lru_bit;
        return way;
    endfunction

endpackage

// File: rtl/lru_miss_ctrl_word_seq_counter.sv
// Word-offset counter for line transfers; wraps modulo the line length.
// The last output flags the final word of a line.
module word_seq_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en)
            count <= count + WIDTH'(1);
    end

    assign last = (count == {WIDTH{1'b1}});

endmodule

// File: rtl/lru_miss_ctrl.sv
// Miss-handling and way-selection FSM for the 2-way set-associative cache.
// Drives the LRU bit array and sequences victim writeback and line fill.
module lru_miss_ctrl
    import lru_miss_ctrl_pkg::*;
#(
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_wr,
    input  logic [INDEX_W-1:0] req_index,
    input  logic               hit0,
    input  logic               hit1,
    input  logic               valid0,
    input  logic               valid1,
    input  logic               dirty0,
    input  logic               dirty1,
    input  logic               lru_bit,
    input  logic               mem_stall,
    input  logic               mem_data_vld,
    output logic [INDEX_W-1:0] lru_index,
    output logic               lru_write,
    output logic               lru_data,
    output logic               way_sel,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [OFF_W-1:0]   mem_offset,
    output logic               fill_en,
    output logic [OFF_W-1:0]   fill_offset,
    output logic               stall,
    output logic               done,
    output logic               err
);

    state_t             state, next_state;
    logic [INDEX_W-1:0] index_q;
    logic               way_q;
    logic               wr_q;
    logic               latch;
    logic               req_way;
    logic               victim_dirty;
    logic               issue_en, issue_clr, issue_last;
    logic               ret_en, ret_clr, ret_last;
    logic [OFF_W-1:0]   issue_cnt, ret_cnt;
    logic               unused_wr;

    assign req_way      = pick_way(hit0, hit1, valid0, valid1, lru_bit);
    assign victim_dirty = req_way ? (valid1 & dirty1) : (valid0 & dirty0);

    // Write misses are write-allocate; the requester applies the write in DONE.
    assign unused_wr = wr_q;

    word_seq_counter #(.WIDTH(OFF_W)) u_issue (
        .clk   (clk),
        .rst   (rst),
        .en    (issue_en),
        .clr   (issue_clr),
        .count (issue_cnt),
        .last  (issue_last)
    );

    word_seq_counter #(.WIDTH(OFF_W)) u_return (
        .clk   (clk),
        .rst   (rst),
        .en    (ret_en),
        .clr   (ret_clr),
        .count (ret_cnt),
        .last  (ret_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            index_q <= '0;
            way_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state <= next_state;
            if (latch) begin
                index_q <= req_index;
                way_q   <= req_way;
                wr_q    <= req_wr;
            end
        end
    end

    always_comb begin
        next_state  = state;
        lru_index   = '0;
        lru_write   = 1'b0;
        lru_data    = 1'b0;
        way_sel     = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_offset  = '0;
        fill_en     = 1'b0;
        fill_offset = '0;
        stall       = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        latch       = 1'b0;
        issue_en    = 1'b0;
        issue_clr   = 1'b0;
        ret_en      = 1'b0;
        ret_clr     = 1'b0;

        case (state)
            IDLE: begin
                issue_clr = 1'b1;
                ret_clr   = 1'b1;
                if (req_valid) begin
                    lru_index = req_index;
                    way_sel   = req_way;
                    if (hit0 || hit1) begin
                        done      = 1'b1;
                        lru_write = 1'b1;
                        lru_data  = ~req_way;
                        err       = hit0 & hit1;
                    end else begin
                        stall      = 1'b1;
                        latch      = 1'b1;
                        next_state = victim_dirty ? WB : RD;
                    end
                end
            end
            WB: begin
                lru_index  = index_q;
                way_sel    = way_q;
                stall      = 1'b1;
                mem_wr     = 1'b1;
                mem_offset = issue_cnt;
                issue_en   = !mem_stall;
                if (issue_last && !mem_stall)
                    next_state = RD;
            end
            RD: begin
                lru_index   = index_q;
                way_sel     = way_q;
                stall       = 1'b1;
                mem_rd      = 1'b1;
                mem_offset  = issue_cnt;
                issue_en    = !mem_stall;
                // Early returns land while later words are still being issued.
                fill_en     = mem_data_vld;
                fill_offset = mem_data_vld ? ret_cnt : '0;
                ret_en      = mem_data_vld;
                if (issue_last && !mem_stall)
                    next_state = FILL;
            end
            FILL: begin
                lru_index   = index_q;
                way_sel     = way_q;
                stall       = 1'b1;
                fill_en     = mem_data_vld;
                fill_offset = mem_data_vld ? ret_cnt : '0;
                ret_en      = mem_data_vld;
                if (ret_last && mem_data_vld)
                    next_state = DONE;
            end
            DONE: begin
                lru_index  = index_q;
                way_sel    = way_q;
                done       = 1'b1;
                lru_write  = 1'b1;
                lru_data   = ~way_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        // Reset silences every output in the cycle it is asserted.
        if (rst) begin
            lru_index   = '0;
            lru_write   = 1'b0;
            lru_data    = 1'b0;
            way_sel     = 1'b0;
            mem_rd      = 1'b0;
            mem_wr      = 1'b0;
            mem_offset  = '0;
            fill_en     = 1'b0;
            fill_offset = '0;
            stall       = 1'b0;
            done        = 1'b0;
            err         = 1'b0;
        end
    end

endmodule

// File: tb/tb_lru_miss_ctrl.sv
// Scoreboard bench for lru_miss_ctrl: stimulus pushes expected events,
// a negedge monitor pops and compares them; a small memory model returns reads.
module tb_lru_miss_ctrl;
    import lru_miss_ctrl_pkg::*;

    typedef struct packed {
        logic       wr;
        logic [1:0] off;
    } mem_op_t;

    typedef struct packed {
        logic       way;
        logic       data;
        logic       err;
        logic [7:0] idx;
    } done_rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_wr;
    logic [7:0] req_index;
    logic       hit0, hit1, valid0, valid1, dirty0, dirty1, lru_bit;
    logic       mem_stall, mem_data_vld;
    logic [7:0] lru_index;
    logic       lru_write, lru_data, way_sel, mem_rd, mem_wr;
    logic [1:0] mem_offset, fill_offset;
    logic       fill_en, stall, done, err;

    int checks = 0;
    int errors = 0;
    int lat;

    mem_op_t   mem_q[$];
    logic [1:0] fill_q[$];
    done_rec_t done_q[$];

    logic               rd_seen = 1'b0;
    logic [MEM_LAT-1:0] rd_pipe = '0;

    lru_miss_ctrl #(.INDEX_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_wr       (req_wr),
        .req_index    (req_index),
        .hit0         (hit0),
        .hit1         (hit1),
        .valid0       (valid0),
        .valid1       (valid1),
        .dirty0       (dirty0),
        .dirty1       (dirty1),
        .lru_bit      (lru_bit),
        .mem_stall    (mem_stall),
        .mem_data_vld (mem_data_vld),
        .lru_index    (lru_index),
        .lru_write    (lru_write),
        .lru_data     (lru_data),
        .way_sel      (way_sel),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_offset   (mem_offset),
        .fill_en      (fill_en),
        .fill_offset  (fill_offset),
        .stall        (stall),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic queueUnderflow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: DUT event with nothing expected at %0t", name, $time);
    endtask

    task automatic applyStimulus(input logic [7:0] idx, input logic wr,
                                 input logic h0, input logic h1,
                                 input logic v0, input logic v1,
                                 input logic d0, input logic d1, input logic lb);
        req_index = idx;  req_wr = wr;
        hit0 = h0;  hit1 = h1;
        valid0 = v0;  valid1 = v1;
        dirty0 = d0;  dirty1 = d1;
        lru_bit = lb;
        req_valid = 1'b1;
    endtask

    task automatic pushOps(input logic wr);
        for (int i = 0; i < WORDS; i++) mem_q.push_back('{wr: wr, off: 2'(i)});
    endtask

    task automatic pushFills(input int n);
        for (int i = 0; i < n; i++) fill_q.push_back(2'(i));
    endtask

    // Holds the request until done, optionally stalling memory or swapping in a new request.
    task automatic waitDone(input int stall_at, input int stall_len, input int chg_at, output int cycles);
        cycles = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (done) begin
                cycles = cyc;
                break;
            end
            @(posedge clk);
            #1;
            mem_stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            if (cyc == chg_at) begin
                req_index = req_index ^ 8'h77;
                hit1 = 1'b1;
            end
        end
        if (cycles == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: no done within 200 cycles at %0t", $time);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        hit0 = 1'b0;
        hit1 = 1'b0;
        mem_stall = 1'b0;
    endtask

    // Memory model: each accepted read returns data MEM_LAT cycles later, in order.
    always @(negedge clk) rd_seen = mem_rd & !mem_stall;

    always @(posedge clk) begin
        #1;
        rd_pipe = {rd_pipe[MEM_LAT-2:0], rd_seen};
        mem_data_vld = rd_pipe[MEM_LAT-1];
    end

    // Monitor: every strobe, fill and completion the DUT presents is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr || mem_rd) begin
                if (mem_q.size() == 0) queueUnderflow("mem_op");
                else begin
                    mem_op_t e;
                    e = mem_q.pop_front();
                    checkOutput("mem_op", {mem_wr, mem_rd, mem_offset}, {e.wr, !e.wr, e.off});
                end
            end
            if (fill_en) begin
                if (fill_q.size() == 0) queueUnderflow("fill");
                else checkOutput("fill_offset", fill_offset, fill_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) queueUnderflow("done");
                else begin
                    done_rec_t d;
                    d = done_q.pop_front();
                    checkOutput("done_way_data_err_idx", {way_sel, lru_data, err, lru_index},
                                {d.way, d.data, d.err, d.idx});
                    checkOutput("done_write_nostall", {lru_write, stall}, 2'b10);
                end
            end
            if (lru_write && !done) checkOutput("lru_write_without_done", lru_write, 1'b0);
            if (err && !done) checkOutput("err_without_done", err, 1'b0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;  req_wr = 1'b0;  req_index = '0;
        hit0 = 1'b0;  hit1 = 1'b0;  valid0 = 1'b0;  valid1 = 1'b0;
        dirty0 = 1'b0;  dirty1 = 1'b0;  lru_bit = 1'b0;
        mem_stall = 1'b0;  mem_data_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_outputs", {lru_index, lru_write, lru_data, way_sel, mem_rd, mem_wr,
                    mem_offset, fill_en, fill_offset, stall, done, err}, 32'h0);

        $display("[TB] test 1: hit on way 1");
        @(posedge clk); #1;
        done_q.push_back('{way: 1'b1, data: 1'b0, err: 1'b0, idx: 8'h05});
        applyStimulus(8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        waitDone(0, 0, 0, lat);
        checkOutput("hit_latency", lat, 1);

        $display("[TB] test 2: miss, way 0 empty");
        @(posedge clk); #1;
        pushOps(1'b0);  pushFills(WORDS);
        done_q.push_back('{way: 1'b0, data: 1'b1, err: 1'b0, idx: 8'h80});
        applyStimulus(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        waitDone(0, 0, 0, lat);
        checkOutput("clean_miss_latency", lat, 8);

        $display("[TB] test 2b: miss, way 1 empty, way 0 dirty");
        @(posedge clk); #1;
        pushOps(1'b0);  pushFills(WORDS);
        done_q.push_back('{way: 1'b1, data: 1'b0, err: 1'b0, idx: 8'h11});
        applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        waitDone(0, 0, 0, lat);
        checkOutput("empty_way1_latency", lat, 8);

        $display("[TB] test 3: dirty victim on way 1");
        @(posedge clk); #1;
        pushOps(1'b1);  pushOps(1'b0);  pushFills(WORDS);
        done_q.push_back('{way: 1'b1, data: 1'b0, err: 1'b0, idx: 8'h21});
        applyStimulus(8'h21, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        waitDone(0, 0, 0, lat);
        checkOutput("dirty_miss_latency", lat, 12);

        $display("[TB] test 3b: LRU picks clean way 0");
        @(posedge clk); #1;
        pushOps(1'b0);  pushFills(WORDS);
        done_q.push_back('{way: 1'b0, data: 1'b1, err: 1'b0, idx: 8'hff});
        applyStimulus(8'hff, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        waitDone(0, 0, 0, lat);
        checkOutput("lru_clean_latency", lat, 8);

        $display("[TB] test 4: memory stall during writeback word 2");
        @(posedge clk); #1;
        mem_q.push_back('{wr: 1'b1, off: 2'd0});
        mem_q.push_back('{wr: 1'b1, off: 2'd1});
        for (int i = 0; i < 4; i++) mem_q.push_back('{wr: 1'b1, off: 2'd2});
        mem_q.push_back('{wr: 1'b1, off: 2'd3});
        pushOps(1'b0);  pushFills(WORDS);
        done_q.push_back('{way: 1'b1, data: 1'b0, err: 1'b0, idx: 8'h22});
        applyStimulus(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        waitDone(3, 3, 0, lat);
        checkOutput("stalled_miss_latency", lat, 15);

        $display("[TB] test 5: reset during fill");
        @(posedge clk); #1;
        pushOps(1'b0);  pushFills(2);
        applyStimulus(8'h90, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_abort_outputs", {lru_index, lru_write, lru_data, way_sel, mem_rd, mem_wr,
                    mem_offset, fill_en, fill_offset, stall, done, err}, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] test 6: double hit, then request change under stall");
        done_q.push_back('{way: 1'b0, data: 1'b1, err: 1'b1, idx: 8'h0a});
        applyStimulus(8'h0a, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        waitDone(0, 0, 0, lat);
        checkOutput("double_hit_latency", lat, 1);

        @(posedge clk); #1;
        pushOps(1'b0);  pushFills(WORDS);
        done_q.push_back('{way: 1'b0, data: 1'b1, err: 1'b0, idx: 8'h33});
        applyStimulus(8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        waitDone(0, 0, 2, lat);
        checkOutput("busy_request_ignored_latency", lat, 8);

        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("mem_q_drained", mem_q.size(), 0);
        checkOutput("fill_q_drained", fill_q.size(), 0);
        checkOutput("done_q_drained", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
